// File: rtl/pc_unit_if.sv
// Fetch-side bundle between the next-PC control of the datapath and pc_unit.
// master = datapath / control side, slave = the PC unit itself.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_epc;
    logic            mret_valid;
    logic [XLEN-1:0] mtvec;
    logic            halt;
    logic            resume;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic            pc_valid;
    logic            misalign;
    logic [XLEN-1:0] epc;
    logic            halted;

    modport master (
        output stall, redirect_valid, redirect_target, trap_valid, trap_epc,
               mret_valid, mtvec, halt, resume,
        input  pc, pc_plus, pc_valid, misalign, epc, halted
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, trap_valid, trap_epc,
               mret_valid, mtvec, halt, resume,
        output pc, pc_plus, pc_valid, misalign, epc, halted
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALTED control, next-PC priority mux, epc and misalign flag.
// Define PC_TRAP_EN to compile in trap/mret/epc and trap-on-misaligned-redirect.
module pc_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              ILEN_BYTES = 4
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } state_e;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(ILEN_BYTES);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            misalign_q, misalign_d;
    logic            halted_q, halted_d;

    logic [XLEN-1:0] pc_plus;
    logic            trap_req;
    logic            mret_req;
    logic [XLEN-1:0] trap_vec;
    logic [XLEN-1:0] trap_epc_in;
    logic            target_misaligned;

    assign pc_plus = pc_q + PC_STEP;

`ifdef PC_TRAP_EN
    logic unused_mtvec_bits;
    assign trap_req          = bus.trap_valid;
    assign mret_req          = bus.mret_valid;
    assign trap_vec          = {bus.mtvec[XLEN-1:2], 2'b00};
    assign trap_epc_in       = bus.trap_epc;
    assign unused_mtvec_bits = ^bus.mtvec[1:0];
`else
    // Trap side is compiled out: its inputs are deliberately ignored.
    logic unused_trap_inputs;
    assign trap_req           = 1'b0;
    assign mret_req           = 1'b0;
    assign trap_vec           = '0;
    assign trap_epc_in        = '0;
    assign unused_trap_inputs = ^{bus.trap_valid, bus.trap_epc, bus.mret_valid, bus.mtvec};
`endif

    assign target_misaligned = |(bus.redirect_target & ALIGN_MASK);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_HALTED: begin
                if (trap_req) begin
                    pc_d  = trap_vec;
                    epc_d = trap_epc_in;
                end else if (mret_req) begin
                    pc_d = epc_q;
                end else if (bus.redirect_valid) begin
                    misalign_d = target_misaligned;
                    if (target_misaligned) begin
`ifdef PC_TRAP_EN
                        pc_d  = trap_vec;
                        epc_d = bus.redirect_target;
`else
                        pc_d  = bus.redirect_target & ~ALIGN_MASK;
`endif
                    end else begin
                        pc_d = bus.redirect_target;
                    end
                end else if (state_q == ST_RUN && !bus.halt && !bus.stall) begin
                    // Halt entry freezes the PC instead of advancing it.
                    pc_d = pc_plus;
                end

                if (state_q == ST_RUN) begin
                    if (bus.halt) begin
                        state_d = ST_HALTED;
                    end
                end else if (bus.resume && !bus.halt) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        pc_valid_d = (state_d == ST_RUN);
        halted_d   = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus  = pc_plus;
    assign bus.pc_valid = pc_valid_q;
    assign bus.misalign = misalign_q;
    assign bus.epc      = epc_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (RESET_VEC=0x100, ILEN_BYTES=4); expectations follow PC_TRAP_EN.
module tb_pc_unit;

`ifdef PC_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0100),
        .ILEN_BYTES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        rst, stall, rv;
        logic [31:0] rt;
        logic        tv;
        logic [31:0] tepc;
        logic        mv, halt, resume;
        logic [31:0] e_pc;
        logic        e_valid, e_mis;
        logic [31:0] e_epc;
        logic        e_halted;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        valid, mis;
        logic [31:0] epc;
        logic        halted;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic rst, stall, rv, input logic [31:0] rt,
                       input logic tv, input logic [31:0] tepc,
                       input logic mv, halt, resume,
                       input logic [31:0] e_pc, input logic e_valid, e_mis,
                       input logic [31:0] e_epc, input logic e_halted);
        vec_t v;
        v.rst = rst; v.stall = stall; v.rv = rv; v.rt = rt;
        v.tv = tv; v.tepc = tepc; v.mv = mv; v.halt = halt; v.resume = resume;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_mis = e_mis;
        v.e_epc = e_epc; v.e_halted = e_halted;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, then compare after the edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        reset               = v.rst;
        bus.stall           = v.stall;
        bus.redirect_valid  = v.rv;
        bus.redirect_target = v.rt;
        bus.trap_valid      = v.tv;
        bus.trap_epc        = v.tepc;
        bus.mret_valid      = v.mv;
        bus.halt            = v.halt;
        bus.resume          = v.resume;
        e.idx = idx; e.pc = v.e_pc; e.valid = v.e_valid; e.mis = v.e_mis;
        e.epc = v.e_epc; e.halted = v.e_halted;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("vec=%0d pc=%h pc_plus=%h valid=%b misalign=%b epc=%h halted=%b",
                 e.idx, bus.pc, bus.pc_plus, bus.pc_valid, bus.misalign, bus.epc, bus.halted);
        check("pc",       e.idx, bus.pc, e.pc);
        check("pc_plus",  e.idx, bus.pc_plus, e.pc + 32'd4);
        check("pc_valid", e.idx, 32'(bus.pc_valid), 32'(e.valid));
        check("misalign", e.idx, 32'(bus.misalign), 32'(e.mis));
        check("epc",      e.idx, bus.epc, e.epc);
        check("halted",   e.idx, 32'(bus.halted), 32'(e.halted));
    endtask

    initial begin
        logic [31:0] e1, e2, e3, e4;
        vec_t        v;
        logic [31:0] hold_pc;

        bus.mtvec = 32'h0000_0803;
        e1 = TRAP_ON ? 32'h200 : 32'h0;
        e2 = TRAP_ON ? 32'h250 : 32'h0;
        e3 = TRAP_ON ? 32'h302 : 32'h0;
        e4 = TRAP_ON ? 32'h602 : 32'h0;

        //   rst st rv target        tv tepc     mv hl rs  pc                           v  mis epc    h
        add(1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h100,                    0, 0, 32'h0, 0);
        add(1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h100,                    0, 0, 32'h0, 0);
        add(0, 0, 1, 32'h998,      1, 32'h555, 0, 1, 0,  32'h100,                    1, 0, 32'h0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h104,                    1, 0, 32'h0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h108,                    1, 0, 32'h0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h108,                    1, 0, 32'h0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h108,                    1, 0, 32'h0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h108,                    1, 0, 32'h0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h10C,                    1, 0, 32'h0, 0);
        add(0, 1, 1, 32'h200,      0, 32'h0,   0, 0, 0,  32'h200,                    1, 0, 32'h0, 0);
        add(0, 0, 0, 32'h0,        1, 32'h200, 0, 0, 0,  TRAP_ON ? 32'h800 : 32'h204, 1, 0, e1,    0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   1, 0, 0,  TRAP_ON ? 32'h200 : 32'h208, 1, 0, e1,    0);
        add(0, 0, 0, 32'h0,        1, 32'h250, 1, 0, 0,  TRAP_ON ? 32'h800 : 32'h20C, 1, 0, e2,    0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   1, 0, 0,  TRAP_ON ? 32'h250 : 32'h210, 1, 0, e2,    0);
        add(0, 0, 1, 32'h302,      0, 32'h0,   0, 0, 0,  TRAP_ON ? 32'h800 : 32'h300, 1, 1, e3,    0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  TRAP_ON ? 32'h804 : 32'h304, 1, 0, e3,    0);
        add(0, 0, 1, 32'h400,      0, 32'h0,   0, 0, 0,  32'h400,                    1, 0, e3,    0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 1, 0,  32'h400,                    0, 0, e3,    1);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h400,                    0, 0, e3,    1);
        add(0, 0, 1, 32'h500,      0, 32'h0,   0, 0, 0,  32'h500,                    0, 0, e3,    1);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 1, 1,  32'h500,                    0, 0, e3,    1);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1,  32'h500,                    1, 0, e3,    0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h504,                    1, 0, e3,    0);
        add(0, 0, 1, 32'h602,      0, 32'h0,   0, 1, 0,  TRAP_ON ? 32'h800 : 32'h600, 0, 1, e4,    1);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1,  TRAP_ON ? 32'h800 : 32'h600, 1, 0, e4,    0);
        add(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,  0, 0, 0,  32'hFFFF_FFFC,              1, 0, e4,    0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h0,                      1, 0, e4,    0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h4,                      1, 0, e4,    0);
        add(1, 0, 1, 32'h303,      1, 32'h777, 0, 0, 0,  32'h100,                    0, 0, 32'h0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h100,                    1, 0, 32'h0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0,  32'h104,                    1, 0, 32'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Long stall: PC must hold for exactly N cycles and then advance once.
        hold_pc = 32'h104;
        v = vecs[vecs.size() - 1];
        v.rst = 0; v.rv = 0; v.tv = 0; v.mv = 0; v.halt = 0; v.resume = 0;
        v.e_valid = 1; v.e_mis = 0; v.e_epc = 32'h0; v.e_halted = 0;
        for (int n = 0; n < 5; n++) begin
            v.stall = 1;
            v.e_pc  = hold_pc;
            apply(v, 100 + n);
        end
        v.stall = 0;
        v.e_pc  = hold_pc + 32'd4;
        apply(v, 105);

        // Halt with stall high, then release both: stall must not matter while halted.
        v.halt = 1; v.stall = 1; v.e_pc = hold_pc + 32'd4; v.e_valid = 0; v.e_halted = 1;
        apply(v, 106);
        v.halt = 0; v.stall = 0;
        apply(v, 107);
        v.resume = 1; v.e_valid = 1; v.e_halted = 0;
        apply(v, 108);
        v.resume = 0; v.e_pc = hold_pc + 32'd8;
        apply(v, 109);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V core front end. Holds the fetch PC and selects the next PC from sequential increment, branch/jump redirect, trap entry and trap return, with stall and halt/resume control. Sits between the next-PC mux logic of the datapath and the instruction memory address port. It replaces a bare reset-to-constant PC register with a small control state machine and a fetch-valid qualifier.

## Interface

Parameters:
- `XLEN`, 32, PC width in bits.
- `RESET_VEC`, `32'h0000_0000`, PC loaded by reset; `XLEN` bits wide.
- `ILEN_BYTES`, 4, sequential increment in bytes; legal values are 4 and 2.

Ports:
- `clk`, input, 1, sole clock; all state updates on the rising edge.
- `reset`, input, 1, synchronous, active-high reset.
- `stall`, input, 1, holds the PC for this cycle.
- `redirect_valid`, input, 1, branch/jump taken.
- `redirect_target`, input, XLEN, branch/jump destination.
- `trap_valid`, input, 1, exception taken.
- `trap_epc`, input, XLEN, PC of the faulting instruction.
- `mret_valid`, input, 1, return from trap.
- `mtvec`, input, XLEN, trap vector base; bits [1:0] are ignored.
- `halt`, input, 1, debug halt request.
- `resume`, input, 1, debug resume request.
- `pc`, output, XLEN, current fetch PC.
- `pc_plus`, output, XLEN, `pc + ILEN_BYTES` modulo 2^XLEN; combinational from `pc`.
- `pc_valid`, output, 1, `pc` is a fetch request this cycle.
- `misalign`, output, 1, registered one-cycle pulse flagging a misaligned redirect.
- `epc`, output, XLEN, saved exception PC.
- `halted`, output, 1, state is HALTED.

## Operation

- State machine states: BOOT, RUN, HALTED.
- Reset:
  - `pc = RESET_VEC`, state = BOOT.
  - `pc_valid = 0`, `misalign = 0`, `epc = 0`, `halted = 0`.
- BOOT always moves to RUN on the next cycle; `pc` is unchanged. Every control input is ignored in BOOT.
- Next-PC priority in RUN and HALTED, highest first:
  1. `trap_valid`: `pc <= {mtvec[XLEN-1:2], 2'b00}` and `epc <= trap_epc`.
  2. `mret_valid`: `pc <= epc`.
  3. `redirect_valid`: `pc <= redirect_target`.
  4. `stall`: hold. Applies in RUN only.
  5. Otherwise in RUN: `pc <= pc_plus`.
  6. Otherwise in HALTED: hold.
- Misaligned redirect: a redirect target with `target % ILEN_BYTES != 0` asserts `misalign` for exactly one cycle. The response depends on the configuration (see Configuration).
- Halt and resume transitions:
  - RUN → HALTED when `halt = 1`. In that cycle the PC takes any trap, mret or redirect update; otherwise it holds. It does not increment.
  - HALTED → RUN when `resume = 1` and `halt = 0`. If both are high, `halt` wins and the unit stays HALTED.
- `pc_valid = 1` only in RUN.
- `halted = 1` only in HALTED.
- Arithmetic wraps modulo 2^XLEN. `pc = 2^XLEN - ILEN_BYTES` increments to 0.

## Timing

- All updates take effect on the edge after the request; latency is 1 cycle. `pc` is registered; `pc_plus` is the only combinational output.
- Fetch-start sequence after `reset` deasserts:
  - Cycle 0: BOOT, `pc_valid = 0`.
  - Cycle 1: RUN, `pc = RESET_VEC`, `pc_valid = 1`.
  - Cycle 2: `pc = RESET_VEC + ILEN_BYTES`.
- Reset asserted mid-operation overrides every other input on that edge. In-flight trap, redirect or halt state is discarded, and `epc` is cleared.
- A stall lasting N cycles holds `pc` for exactly N cycles.
- A stall together with a redirect, trap or mret still takes the redirect, trap or mret.
- Trap and mret in the same cycle: the trap wins and `epc` is overwritten.
- `misalign` is registered. It is high in the cycle after the offending redirect, aligned with the new `pc`.

## Configuration

- `PC_TRAP_EN`, defined:
  - Trap, mret and epc logic is compiled in.
  - A misaligned redirect is converted into a trap: `pc <= mtvec` with bits [1:0] cleared, and `epc <= redirect_target`.
- `PC_TRAP_EN`, undefined:
  - `trap_valid`, `trap_epc`, `mret_valid` and `mtvec` are ignored, and `epc` is tied to 0.
  - A misaligned redirect loads the target with its low `log2(ILEN_BYTES)` bits cleared.
  - `misalign` pulses in both configurations.

## Test plan

- Reset, `RESET_VEC = 0x100`, no other inputs: `pc_valid` is 0 for one cycle, then `pc` runs 0x100, 0x104, 0x108.
- Stall for 3 cycles at `pc = 0x108`: `pc` stays 0x108 for 3 cycles, then 0x10C.
- Redirect to 0x200 while `stall = 1`, followed on the next cycle by a trap with `mtvec = 0x803`, `trap_epc = 0x200`:
  - `pc` goes 0x200, then 0x800.
  - `epc` = 0x200.
  - An mret afterwards gives `pc = 0x200`.
- Redirect to 0x302:
  - `PC_TRAP_EN` defined: `misalign` pulses 1 cycle, `pc` = mtvec-aligned value, `epc` = 0x302.
  - `PC_TRAP_EN` undefined: `misalign` pulses 1 cycle, `pc` = 0x300.
- Halt at `pc = 0x400`:
  - `halted = 1`, `pc_valid = 0`, `pc` stays 0x400.
  - A redirect to 0x500 while halted gives `pc = 0x500` and the unit stays halted.
  - `resume` → RUN, and `pc` goes 0x500, 0x504.
- `pc = 0xFFFF_FFFC` increments to 0x0000_0000. Reset asserted during a trap cycle gives `pc = RESET_VEC` and `epc = 0`.
